iq_unpack: RTL and testbench
============================

# iq_unpack

Parametrised byte-stream-to-IQ unpacker: reads interleaved raw IQ bytes from an upstream FWFT FIFO and writes sign-extended, fixed-point-scaled I and Q words into separate downstream I and Q FIFOs. It generalises the fixed two-byte-per-component read-IQ stage with:
- 1- or 2-byte components
- two's-complement or offset-binary input
- optional I/Q swap
- a round-robin channel tag for multi-channel captures

It sits between the raw-input FIFO and the demodulator front end.

## Interface
Parameters:
- DATA_WIDTH, 32, width of I/Q output words
- SAMPLE_BYTES, 2, bytes per component; legal values 1 or 2
- QUANT_BITS, 10, left shift applied after sign extension (fixed-point scale)
- NUM_CH, 1, number of interleaved channels; must be ≥1
- CH_WIDTH, $clog2(NUM_CH) (min 1), width of channel tag

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  reset, asynchronous, active-low
- in_dout  in  8  upstream FIFO data; valid whenever in_empty=0
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  upstream FIFO pop
- offset_binary  in  1  1 = components are unsigned offset-binary
- swap_iq  in  1  1 = first component in stream is Q
- I_din  out  DATA_WIDTH  I word to I FIFO
- I_wr_en  out  1  I FIFO push
- I_full  in  1  I FIFO full
- Q_din  out  DATA_WIDTH  Q word to Q FIFO
- Q_wr_en  out  1  Q FIFO push
- Q_full  in  1  Q FIFO full
- ch_out  out  CH_WIDTH  channel index of the pair currently presented
- sample_count  out  32  number of IQ pairs written since reset

## Operation
- Byte order per sample: comp A low byte, then comp A high byte if SAMPLE_BYTES=2; then comp B in the same order.
  - Comp A = I, comp B = Q when swap_iq=0; reversed when swap_iq=1.
- offset_binary and swap_iq are latched when byte index 0 of each sample is consumed. They are constant for the whole sample.
- Conversion, applied per component:
  - Raw value r has 8·SAMPLE_BYTES bits.
  - If offset_binary, invert MSB of r.
  - Sign-extend to DATA_WIDTH.
  - Shift left QUANT_BITS, keeping the low DATA_WIDTH bits (no saturation).
- FSM with two states:
  - COLLECT:
    - in_rd_en = ~in_empty, combinational.
    - Each popped byte is stored at byte index k, and k increments.
    - When byte 2·SAMPLE_BYTES−1 is popped, k returns to 0 and the next state is WRITE.
  - WRITE:
    - in_rd_en=0.
    - When I_full=0 and Q_full=0, I_wr_en = Q_wr_en = 1 for exactly one cycle; the next state is COLLECT.
    - On that cycle, ch_out increments (wraps NUM_CH−1→0) and sample_count increments (wraps 2^32−1→0).
    - If either FIFO is full, stay in WRITE with both write enables low and data held.
- I_wr_en and Q_wr_en are always asserted together; a one-sided write is illegal.
- I_din and Q_din are driven from holding registers and are stable throughout WRITE.

## Timing
- Reset (reset=0, async) forces:
  - state = COLLECT, k=0
  - in_rd_en=0, I_wr_en=0, Q_wr_en=0
  - I_din=0, Q_din=0
  - ch_out=0, sample_count=0
- Reset mid-sample discards the partially collected bytes. Bytes already popped are not replayed.
- Throughput with no stalls: one IQ pair per 2·SAMPLE_BYTES+1 cycles (5 cycles at SAMPLE_BYTES=2, 3 cycles at SAMPLE_BYTES=1).
- Latency from the last byte pop to I_wr_en: 1 cycle.
- An in_empty gap in COLLECT pauses k without loss.
- I_full or Q_full asserted in WRITE stalls indefinitely. No bytes are popped while stalled.

## Test plan
- SAMPLE_BYTES=2, QUANT_BITS=10, bytes 34 12 78 56 → I_din=0x0048D000, Q_din=0x0159E000, ch_out=0, sample_count→1.
- Negative full scale: bytes 00 80 FF 7F → I=0xFE000000, Q=0x01FFFC00. With offset_binary=1, the same bytes → I=0x00000000, Q=0xFFFFFC00.
- SAMPLE_BYTES=1, NUM_CH=3, bytes 80 7F repeated 4 times → I=0xFFFE0000, Q=0x0001FC00. ch_out sequence 0,1,2,0; wr pulses every 3 cycles.
- swap_iq=1 with bytes 34 12 78 56 → I=0x0159E000, Q=0x0048D000. Toggling swap_iq mid-sample has no effect until the next sample.
- Hold Q_full=1 for 7 cycles during WRITE → no writes, in_rd_en=0, data held. Exactly one write pair occurs after release.
- Assert reset after 3 of 4 bytes → outputs at reset values. The next 4 bytes form a complete sample, sample_count=1.

Source files
------------

// File: rtl/iq_unpack.sv
// iq_unpack
// Pulls interleaved raw IQ bytes from an upstream FWFT FIFO and writes
// sign-extended, fixed-point-scaled I and Q words to separate I and Q FIFOs.
//
// Parameters:
//   DATA_WIDTH   - width of I/Q output words
//   SAMPLE_BYTES - bytes per component (1 or 2)
//   QUANT_BITS   - left shift applied after sign extension
//   NUM_CH       - number of interleaved channels (>= 1)
//   CH_WIDTH     - width of the channel tag
//
// Ports:
//   clock, reset          - system clock, asynchronous active-low reset
//   in_dout/in_empty      - upstream FIFO data and empty flag
//   in_rd_en              - upstream FIFO pop
//   offset_binary         - components are unsigned offset-binary
//   swap_iq               - first component in the stream is Q
//   I_din/I_wr_en/I_full  - I FIFO write side
//   Q_din/Q_wr_en/Q_full  - Q FIFO write side
//   ch_out                - channel index of the pair currently presented
//   sample_count          - IQ pairs written since reset
module iq_unpack #(
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_BYTES = 2,
   parameter int QUANT_BITS   = 10,
   parameter int NUM_CH       = 1,
   parameter int CH_WIDTH     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            in_dout,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   input  logic                  offset_binary,
   input  logic                  swap_iq,
   output logic [DATA_WIDTH-1:0] I_din,
   output logic                  I_wr_en,
   input  logic                  I_full,
   output logic [DATA_WIDTH-1:0] Q_din,
   output logic                  Q_wr_en,
   input  logic                  Q_full,
   output logic [CH_WIDTH-1:0]   ch_out,
   output logic [31:0]           sample_count
);

   localparam int         NB     = 2 * SAMPLE_BYTES;   // bytes per IQ pair
   localparam int         SW     = 8 * SAMPLE_BYTES;   // bits per component
   localparam logic [1:0] K_LAST = 2'(NB - 1);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] WRITE   = 1'b1;

   logic [0:0]            state;
   logic [1:0]            k;
   logic [8*(NB-1)-1:0]   sample_q;   // all bytes except the last one
   logic                  ob_q;
   logic                  sw_q;
   logic                  pop;
   logic                  wr;
   logic [8*NB-1:0]       full_sample;
   logic [SW-1:0]         raw_a;
   logic [SW-1:0]         raw_b;
   logic [DATA_WIDTH-1:0] conv_a;
   logic [DATA_WIDTH-1:0] conv_b;

   function automatic logic [DATA_WIDTH-1:0] convert(input logic [SW-1:0] r,
                                                     input logic           ob);
      logic [SW-1:0]                v;
      logic signed [DATA_WIDTH-1:0] ext;
      v         = r;
      v[SW-1]   = r[SW-1] ^ ob;
      ext       = DATA_WIDTH'($signed(v));
      return ext << QUANT_BITS;
   endfunction

   always_comb begin
      // Gated with reset so the pop is held low while reset is asserted.
      pop         = reset & (state == COLLECT) & ~in_empty;
      wr          = (state == WRITE) & ~I_full & ~Q_full;
      // The final byte is converted straight off the FIFO output so the
      // holding registers load on the same edge it is popped.
      full_sample = {in_dout, sample_q};
      raw_a       = full_sample[SW-1:0];
      raw_b       = full_sample[2*SW-1:SW];
      conv_a      = convert(raw_a, ob_q);
      conv_b      = convert(raw_b, ob_q);
   end

   assign in_rd_en = pop;
   assign I_wr_en  = wr;
   assign Q_wr_en  = wr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= COLLECT;
         k            <= '0;
         sample_q     <= '0;
         ob_q         <= 1'b0;
         sw_q         <= 1'b0;
         I_din        <= '0;
         Q_din        <= '0;
         ch_out       <= '0;
         sample_count <= '0;
      end else if (state == COLLECT) begin
         if (pop) begin
            // Byte 0 is never the last byte, so the mode latched here is
            // already visible when the final byte is converted.
            if (k == 2'd0) begin
               ob_q <= offset_binary;
               sw_q <= swap_iq;
            end
            if (k == K_LAST) begin
               k     <= '0;
               state <= WRITE;
               I_din <= sw_q ? conv_b : conv_a;
               Q_din <= sw_q ? conv_a : conv_b;
            end else begin
               sample_q[int'(k)*8 +: 8] <= in_dout;
               k                        <= k + 2'd1;
            end
         end
      end else begin
         if (wr) begin
            state        <= COLLECT;
            sample_count <= sample_count + 32'd1;
            if (ch_out == CH_WIDTH'(NUM_CH - 1))
               ch_out <= '0;
            else
               ch_out <= ch_out + CH_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_iq_unpack.sv
// tb_iq_unpack
// Scoreboard bench for iq_unpack. Two instances: a default 2-byte,
// single-channel unit and a 1-byte, three-channel unit. Expected pairs are
// queued when a sample's bytes are driven and compared when the write fires.
module tb_iq_unpack;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] q;
      logic [1:0]  ch;
      logic [31:0] cnt;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // 2-byte unit
   logic [7:0]  d2_dout  = 8'h00;
   logic        d2_empty = 1'b1;
   logic        d2_rd_en;
   logic        d2_ob    = 1'b0;
   logic        d2_sw    = 1'b0;
   logic [31:0] d2_I_din, d2_Q_din;
   logic        d2_I_wr_en, d2_Q_wr_en;
   logic        d2_I_full = 1'b0;
   logic        d2_Q_full = 1'b0;
   logic [0:0]  d2_ch;
   logic [31:0] d2_count;

   // 1-byte, 3-channel unit
   logic [7:0]  d1_dout  = 8'h00;
   logic        d1_empty = 1'b1;
   logic        d1_rd_en;
   logic        d1_ob    = 1'b0;
   logic        d1_sw    = 1'b0;
   logic [31:0] d1_I_din, d1_Q_din;
   logic        d1_I_wr_en, d1_Q_wr_en;
   logic        d1_I_full = 1'b0;
   logic        d1_Q_full = 1'b0;
   logic [1:0]  d1_ch;
   logic [31:0] d1_count;

   iq_unpack #(.DATA_WIDTH(32), .SAMPLE_BYTES(2), .QUANT_BITS(10), .NUM_CH(1)) u_dut2 (
      .clock(clock), .reset(reset),
      .in_dout(d2_dout), .in_empty(d2_empty), .in_rd_en(d2_rd_en),
      .offset_binary(d2_ob), .swap_iq(d2_sw),
      .I_din(d2_I_din), .I_wr_en(d2_I_wr_en), .I_full(d2_I_full),
      .Q_din(d2_Q_din), .Q_wr_en(d2_Q_wr_en), .Q_full(d2_Q_full),
      .ch_out(d2_ch), .sample_count(d2_count)
   );

   iq_unpack #(.DATA_WIDTH(32), .SAMPLE_BYTES(1), .QUANT_BITS(10), .NUM_CH(3)) u_dut1 (
      .clock(clock), .reset(reset),
      .in_dout(d1_dout), .in_empty(d1_empty), .in_rd_en(d1_rd_en),
      .offset_binary(d1_ob), .swap_iq(d1_sw),
      .I_din(d1_I_din), .I_wr_en(d1_I_wr_en), .I_full(d1_I_full),
      .Q_din(d1_Q_din), .Q_wr_en(d1_Q_wr_en), .Q_full(d1_Q_full),
      .ch_out(d1_ch), .sample_count(d1_count)
   );

   exp_t        sb2[$];
   exp_t        sb1[$];
   exp_t        e2, e1;
   logic [31:0] exp_cnt2 = 0;
   int          d2_wr_cnt = 0;
   bit          d2_chk_period = 0, d2_last_valid = 0;
   int unsigned d2_last = 0;
   bit          d1_chk_period = 0, d1_last_valid = 0;
   int unsigned d1_last = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference conversion for a 16-bit component, QUANT_BITS=10.
   function automatic logic [31:0] model16(input logic [15:0] r, input bit ob);
      int v;
      v = int'(r);
      if (ob) v = v ^ 32'h8000;
      if (v >= 32768) v = v - 65536;
      return 32'(v * 1024);
   endfunction

   // Tasks start and end at posedge+2 so inputs never move near a sample point.
   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic push2(input logic [7:0] b);
      int t;
      d2_dout  = b;
      d2_empty = 1'b0;
      t = 0;
      @(negedge clock);
      while (!d2_rd_en && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!d2_rd_en) check("d2_pop_timeout", 0, 1);
      @(posedge clock);
      #2;
      d2_empty = 1'b1;
   endtask

   task automatic push1(input logic [7:0] b);
      int t;
      d1_dout  = b;
      d1_empty = 1'b0;
      t = 0;
      @(negedge clock);
      while (!d1_rd_en && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!d1_rd_en) check("d1_pop_timeout", 0, 1);
      @(posedge clock);
      #2;
      d1_empty = 1'b1;
   endtask

   task automatic send2(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input bit ob, input bit sw,
                        input logic [31:0] ei, input logic [31:0] eq, input bit gaps);
      d2_ob = ob;
      d2_sw = sw;
      sb2.push_back(exp_t'{i: ei, q: eq, ch: 2'd0, cnt: exp_cnt2});
      exp_cnt2++;
      if (gaps) idle($urandom_range(0, 2));
      push2(b0);
      if (gaps) idle($urandom_range(0, 2));
      push2(b1);
      if (gaps) idle($urandom_range(0, 2));
      push2(b2);
      if (gaps) idle($urandom_range(0, 2));
      push2(b3);
   endtask

   always @(negedge clock) begin
      if (reset && (d2_I_wr_en || d2_Q_wr_en)) begin
         check("d2_wr_pair", d2_Q_wr_en, d2_I_wr_en);
         d2_wr_cnt++;
         if (d2_chk_period && d2_last_valid) check("d2_period", cyc - d2_last, 5);
         d2_last       = cyc;
         d2_last_valid = 1;
         if (sb2.size() == 0) check("d2_unexpected_wr", 1, 0);
         else begin
            e2 = sb2.pop_front();
            check("d2_I", d2_I_din, e2.i);
            check("d2_Q", d2_Q_din, e2.q);
            check("d2_ch", d2_ch, 0);
            check("d2_cnt", d2_count, e2.cnt);
         end
      end
   end

   always @(negedge clock) begin
      if (reset && (d1_I_wr_en || d1_Q_wr_en)) begin
         check("d1_wr_pair", d1_Q_wr_en, d1_I_wr_en);
         if (d1_chk_period && d1_last_valid) check("d1_period", cyc - d1_last, 3);
         d1_last       = cyc;
         d1_last_valid = 1;
         if (sb1.size() == 0) check("d1_unexpected_wr", 1, 0);
         else begin
            e1 = sb1.pop_front();
            check("d1_I", d1_I_din, e1.i);
            check("d1_Q", d1_Q_din, e1.q);
            check("d1_ch", d1_ch, e1.ch);
            check("d1_cnt", d1_count, e1.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0]  b[4];
      logic [31:0] ma, mb;
      bit          ob, sw;
      int          wc;

      // Reset state, with data offered upstream
      d2_dout  = 8'h55;
      d2_empty = 1'b0;
      #12;
      check("rst_rd_en", d2_rd_en, 0);
      check("rst_wr_en", {d2_I_wr_en, d2_Q_wr_en}, 0);
      check("rst_I_din", d2_I_din, 0);
      check("rst_Q_din", d2_Q_din, 0);
      check("rst_ch", d2_ch, 0);
      check("rst_count", d2_count, 0);
      d2_empty = 1'b1;
      @(posedge clock); #2;
      reset = 1'b1;
      @(posedge clock); #2;

      // Back-to-back samples: basic, negative full scale, offset binary
      d2_chk_period = 1;
      send2(8'h34, 8'h12, 8'h78, 8'h56, 0, 0, 32'h0048D000, 32'h0159E000, 0);
      send2(8'h00, 8'h80, 8'hFF, 8'h7F, 0, 0, 32'hFE000000, 32'h01FFFC00, 0);
      send2(8'h00, 8'h80, 8'hFF, 8'h7F, 1, 0, 32'h00000000, 32'hFFFFFC00, 0);
      idle(3);
      d2_chk_period = 0;
      check("count_after_3", d2_count, 3);

      // I/Q swap, then a swap toggle after byte 0 that must not take effect
      send2(8'h34, 8'h12, 8'h78, 8'h56, 0, 1, 32'h0159E000, 32'h0048D000, 0);
      sb2.push_back(exp_t'{i: 32'h0048D000, q: 32'h0159E000, ch: 2'd0, cnt: exp_cnt2});
      exp_cnt2++;
      d2_sw = 1'b0;
      push2(8'h34);
      d2_sw = 1'b1;
      push2(8'h12);
      push2(8'h78);
      push2(8'h56);
      d2_sw = 1'b0;
      idle(2);
      check("count_after_swap", d2_count, 5);

      // Q FIFO full stall for 7 cycles with data waiting upstream
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      ma = model16({b[1], b[0]}, 0);
      mb = model16({b[3], b[2]}, 0);
      d2_Q_full = 1'b1;
      send2(b[0], b[1], b[2], b[3], 0, 0, ma, mb, 0);
      d2_dout  = 8'hAA;
      d2_empty = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         check("stall_wr_en", {d2_I_wr_en, d2_Q_wr_en}, 0);
         check("stall_rd_en", d2_rd_en, 0);
         check("stall_I_hold", d2_I_din, ma);
         check("stall_Q_hold", d2_Q_din, mb);
         @(posedge clock); #2;
      end
      wc        = d2_wr_cnt;
      d2_Q_full = 1'b0;
      d2_empty  = 1'b1;
      idle(4);
      check("stall_one_write", d2_wr_cnt - wc, 1);

      // Random samples and modes with empty gaps between bytes
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
         ob = 1'($urandom);
         sw = 1'($urandom);
         ma = model16({b[1], b[0]}, ob);
         mb = model16({b[3], b[2]}, ob);
         if (sw) send2(b[0], b[1], b[2], b[3], ob, sw, mb, ma, 1);
         else    send2(b[0], b[1], b[2], b[3], ob, sw, ma, mb, 1);
      end
      idle(3);
      check("count_after_rand", d2_count, exp_cnt2);

      // Reset after 3 of 4 bytes: partial sample discarded
      d2_ob = 1'b0;
      d2_sw = 1'b0;
      push2(8'hDE);
      push2(8'hAD);
      push2(8'hBE);
      reset    = 1'b0;
      d2_dout  = 8'h11;
      d2_empty = 1'b0;
      @(negedge clock);
      check("midrst_rd_en", d2_rd_en, 0);
      check("midrst_wr_en", {d2_I_wr_en, d2_Q_wr_en}, 0);
      check("midrst_I_din", d2_I_din, 0);
      check("midrst_Q_din", d2_Q_din, 0);
      check("midrst_count", d2_count, 0);
      d2_empty = 1'b1;
      @(posedge clock); #2;
      reset    = 1'b1;
      exp_cnt2 = 0;
      @(posedge clock); #2;
      send2(8'h34, 8'h12, 8'h78, 8'h56, 0, 0, 32'h0048D000, 32'h0159E000, 0);
      idle(2);
      check("post_rst_count", d2_count, 1);

      // 1-byte, 3-channel unit: 80 7F four times, back to back
      d1_chk_period = 1;
      for (int n = 0; n < 4; n++) begin
         sb1.push_back(exp_t'{i: 32'hFFFE0000, q: 32'h0001FC00, ch: 2'(n % 3), cnt: 32'(n)});
         push1(8'h80);
         push1(8'h7F);
      end
      idle(3);
      d1_chk_period = 0;
      check("d1_count", d1_count, 4);
      check("d1_ch_wrap", d1_ch, 1);

      check("d2_sb_drained", sb2.size(), 0);
      check("d1_sb_drained", sb1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
